// File: rtl/tinyml_pkg.sv
// Shared types and helpers for the tinyML post-GEMV stages: FSM state encoding,
// default geometry and the signed ReLU used on captured GEMV outputs.
package tinyml_pkg;

   localparam int DW        = 8;
   localparam int ROWS_DEF  = 128;
   localparam int LANES_DEF = 8;
   localparam int BEATS     = ROWS_DEF / LANES_DEF;

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   // Negative (MSB set) elements clamp to zero; everything else passes through.
   function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
      return x[DW-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/relu_argmax_lane_max.sv
// lane_max: combinational max over one beat of non-negative elements; reports
// the value and its lane index, lowest lane winning on ties.
module lane_max
   import tinyml_pkg::*;
#(
   parameter int DATA_WIDTH = DW,
   parameter int LANES      = LANES_DEF,
   parameter int IDX_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic [LANES*DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0]       o_val,
   output logic [IDX_W-1:0]            o_idx
);

   always_comb begin
      o_val = i_data[DATA_WIDTH-1:0];
      o_idx = '0;
      // Strictly greater only, so an equal later lane never displaces an earlier one.
      for (int l = 1; l < LANES; l++) begin
         if (i_data[l*DATA_WIDTH +: DATA_WIDTH] > o_val) begin
            o_val = i_data[l*DATA_WIDTH +: DATA_WIDTH];
            o_idx = IDX_W'(l);
         end
      end
   end

endmodule

// File: rtl/relu_argmax.sv
// relu_argmax: captures the GEMV output vector, streams ReLU'd beats over valid/ready
// and tracks the argmax. Argmax logic is built only with RELU_ARGMAX_ARGMAX_EN defined.
module relu_argmax
   import tinyml_pkg::*;
#(
   parameter int DATA_WIDTH = DW,
   parameter int ROWS       = ROWS_DEF,
   parameter int LANES      = LANES_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ROWS*DATA_WIDTH-1:0]  y_in,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic                        out_last,
   output logic [$clog2(ROWS)-1:0]     argmax_idx,
   output logic [DATA_WIDTH-1:0]       argmax_val,
   output logic                        done
);

   localparam int NBEATS = ROWS / LANES;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int IW     = $clog2(ROWS);
   localparam int LIW    = (LANES > 1) ? $clog2(LANES) : 1;

   if (ROWS % LANES != 0) begin : g_bad_geometry
      $error("relu_argmax: ROWS (%0d) must be a multiple of LANES (%0d)", ROWS, LANES);
   end
   if (DATA_WIDTH != DW) begin : g_bad_width
      $error("relu_argmax: DATA_WIDTH (%0d) must match tinyml_pkg::DW (%0d)", DATA_WIDTH, DW);
   end

   state_t                      r_state;
   logic [ROWS*DATA_WIDTH-1:0]  r_buf;
   logic [BW-1:0]               r_beat;
   logic                        r_busy;
   logic                        r_valid;
   logic                        r_last;
   logic                        r_done;
   logic [LANES*DATA_WIDTH-1:0] w_data;

   // Current beat straight from the capture buffer; stable while stalled because
   // neither buffer nor beat counter moves without an accept.
   always_comb begin
      w_data = '0;
      for (int l = 0; l < LANES; l++) begin
         w_data[l*DATA_WIDTH +: DATA_WIDTH] =
            relu(r_buf[(int'(r_beat)*LANES + l)*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_buf   <= '0;
         r_beat  <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_buf   <= y_in;
                  r_beat  <= '0;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
                  r_last  <= (NBEATS == 1);
                  r_state <= STREAM;
               end
            end
            STREAM: begin
               if (r_valid && out_ready) begin
                  r_beat <= r_beat + BW'(1);
                  r_last <= (int'(r_beat) + 1 == NBEATS - 1);
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               // start seen here is dropped; the next one is taken from IDLE.
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign done      = r_done;
   assign out_data  = r_valid ? w_data : '0;

`ifdef RELU_ARGMAX_ARGMAX_EN
   logic [DATA_WIDTH-1:0] r_max_val;
   logic [IW-1:0]         r_max_idx;
   logic [DATA_WIDTH-1:0] r_am_val;
   logic [IW-1:0]         r_am_idx;
   logic [DATA_WIDTH-1:0] w_lane_val;
   logic [LIW-1:0]        w_lane_idx;
   logic [DATA_WIDTH-1:0] w_new_val;
   logic [IW-1:0]         w_new_idx;

   lane_max #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .IDX_W      (LIW)
   ) u_lane_max (
      .i_data (w_data),
      .o_val  (w_lane_val),
      .o_idx  (w_lane_idx)
   );

   // Beats arrive in index order, so strict-greater keeps the earliest index overall.
   always_comb begin
      w_new_val = r_max_val;
      w_new_idx = r_max_idx;
      if (w_lane_val > r_max_val) begin
         w_new_val = w_lane_val;
         w_new_idx = IW'(int'(r_beat) * LANES) + IW'(w_lane_idx);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_max_val <= '0;
         r_max_idx <= '0;
         r_am_val  <= '0;
         r_am_idx  <= '0;
      end else if (r_state == IDLE && start) begin
         r_max_val <= '0;
         r_max_idx <= '0;
      end else if (r_state == STREAM && r_valid && out_ready) begin
         r_max_val <= w_new_val;
         r_max_idx <= w_new_idx;
         // Result becomes visible together with the done pulse and then holds.
         if (r_last) begin
            r_am_val <= w_new_val;
            r_am_idx <= w_new_idx;
         end
      end
   end

   assign argmax_idx = r_am_idx;
   assign argmax_val = r_am_val;
`else
   assign argmax_idx = '0;
   assign argmax_val = '0;
`endif

endmodule

// File: tb/tb_relu_argmax.sv
// Randomized self-checking bench for relu_argmax (ROWS=16, LANES=4) against a
// behavioural ReLU/argmax model; argmax expectations follow RELU_ARGMAX_ARGMAX_EN.
module tb_relu_argmax;

   localparam int DW    = 8;
   localparam int ROWS  = 16;
   localparam int LANES = 4;
   localparam int NB    = ROWS / LANES;
   localparam int IW    = $clog2(ROWS);
`ifdef RELU_ARGMAX_ARGMAX_EN
   localparam bit AM_EN = 1'b1;
`else
   localparam bit AM_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  start = 1'b0;
   logic                  out_ready = 1'b0;
   logic [ROWS*DW-1:0]    y_in = '0;
   logic                  busy, out_valid, out_last, done;
   logic [LANES*DW-1:0]   out_data;
   logic [IW-1:0]         argmax_idx;
   logic [DW-1:0]         argmax_val;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   relu_argmax #(.DATA_WIDTH(DW), .ROWS(ROWS), .LANES(LANES)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .y_in       (y_in),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .argmax_idx (argmax_idx),
      .argmax_val (argmax_val),
      .done       (done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] x);
      return ($signed(x) < 0) ? '0 : x;
   endfunction

   // Largest post-ReLU value, then the first position holding it.
   task automatic model(input logic [ROWS*DW-1:0] v, output logic [IW-1:0] idx,
                        output logic [DW-1:0] val);
      val = '0;
      for (int i = 0; i < ROWS; i++)
         if (relu_m(v[i*DW +: DW]) > val) val = relu_m(v[i*DW +: DW]);
      idx = '0;
      for (int i = ROWS - 1; i >= 0; i--)
         if (relu_m(v[i*DW +: DW]) == val) idx = IW'(i);
   endtask

   task automatic rand_vec(output logic [ROWS*DW-1:0] v);
      for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = DW'($urandom);
   endtask

   // Called at a negedge. mode: 0 always ready, 1 scripted stalls, 2 random ready.
   task automatic run(input logic [ROWS*DW-1:0] v, input int mode, input bit mid_start,
                      input bit poke_done, output int done_cyc);
      logic [LANES*DW-1:0] exp_beat, prev_data;
      logic [ROWS*DW-1:0]  junk;
      logic [IW-1:0]       eidx;
      logic [DW-1:0]       eval_;
      bit                  prev_stall, seen_done;
      int                  nb, cyc, last_acc;
      model(v, eidx, eval_);
      y_in = v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rand_vec(junk);
      y_in = junk;
      chk("first_valid", out_valid, 1);
      chk("busy_on", busy, 1);
      nb = 0; cyc = 1; last_acc = 0; done_cyc = -1;
      prev_stall = 0; prev_data = '0; seen_done = 0;
      while (!seen_done && cyc < 200) begin
         if (done) begin
            seen_done = 1;
            done_cyc  = cyc;
         end else begin
            if (out_valid) begin
               for (int l = 0; l < LANES; l++)
                  exp_beat[l*DW +: DW] = relu_m(v[(nb*LANES + l)*DW +: DW]);
               chk("beat_data", out_data, exp_beat);
               chk("beat_last", out_last, (nb == NB - 1));
               if (prev_stall) chk("stall_hold", out_data, prev_data);
            end
            if (!AM_EN) chk("argmax_tied", {argmax_idx, argmax_val}, 0);
            case (mode)
               0:       out_ready = 1'b1;
               1:       out_ready = !((cyc >= 2 && cyc <= 4) || (cyc > 4 && cyc % 2 == 1));
               default: out_ready = 1'($urandom_range(0, 1));
            endcase
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
               nb++;
               last_acc = cyc;
            end
            start = mid_start && (cyc == 2);
            @(negedge clk);
            start = 1'b0;
            cyc++;
         end
      end
      chk("done_seen", seen_done, 1);
      chk("accepts", nb, NB);
      chk("done_after_last", done_cyc, last_acc + 1);
      chk("valid_at_done", out_valid, 0);
      chk("argmax_idx", argmax_idx, AM_EN ? eidx : '0);
      chk("argmax_val", argmax_val, AM_EN ? eval_ : '0);
      if (poke_done) begin
         rand_vec(junk);
         y_in  = junk;
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse", done, 0);
      chk("busy_off", busy, 0);
      chk("idle_valid", out_valid, 0);
      chk("argmax_hold", {argmax_idx, argmax_val}, AM_EN ? {eidx, eval_} : '0);
   endtask

   initial begin
      logic [ROWS*DW-1:0] v;
      int dc;

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last_done", {out_last, done}, 0);
      chk("rst_argmax", {argmax_idx, argmax_val}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = DW'(i);
      run(v, 0, 0, 0, dc);
      chk("done_latency", dc, 5);

      for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = 8'h80 | DW'($urandom_range(0, 127));
      v[7*DW +: DW] = 8'h9C;
      run(v, 2, 0, 0, dc);

      for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = 8'h10;
      v[3*DW +: DW] = 8'h50;
      v[9*DW +: DW] = 8'h50;
      run(v, 0, 0, 0, dc);

      rand_vec(v);
      run(v, 1, 0, 0, dc);

      // Mid-stream start and start-during-done are both ignored; then back-to-back run.
      rand_vec(v);
      run(v, 0, 1, 1, dc);
      rand_vec(v);
      run(v, 0, 0, 0, dc);

      for (int k = 0; k < 6; k++) begin
         rand_vec(v);
         run(v, 2, 0, 0, dc);
      end

      // Reset while beat 2 is on the bus.
      rand_vec(v);
      y_in = v;
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_last_done", {out_last, done}, 0);
      chk("arst_argmax", {argmax_idx, argmax_val}, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_done", {done, out_valid}, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {busy, out_valid, done}, 0);
      rand_vec(v);
      run(v, 2, 0, 0, dc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/relu_argmax.md
Name: relu_argmax

Overview:
- Downstream stage of the GEMV engine.
- On a start pulse, aligned with GEMV `done`, it captures the full output vector `y`.
- It applies ReLU (signed interpretation) and streams the result out LANES elements per beat over a valid/ready handshake.
- In parallel it tracks the argmax of the post-ReLU vector, giving the classification result for the tinyML inference path.

Parameters:
- DATA_WIDTH, 8, element width; two's-complement signed.
- ROWS, 128, vector length; must equal the GEMV ROWS.
- LANES, 8, elements per output beat; ROWS % LANES == 0 required (elaboration-time $error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle capture pulse; tie to GEMV `done`.
- y_in  in  ROWS x DATA_WIDTH  vector to capture; sampled only when start is accepted.
- busy  out  1  high from the cycle after start is accepted until `done` deasserts.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LANES x DATA_WIDTH  post-ReLU elements [beat*LANES +: LANES].
- out_last  out  1  high with the final beat.
- argmax_idx  out  clog2(ROWS)  index of the maximum post-ReLU element.
- argmax_val  out  DATA_WIDTH  value at argmax_idx.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst=0, asynchronous) clears all state:
  - state=IDLE; busy, out_valid, out_last, done all 0.
  - out_data, argmax_idx, argmax_val = 0.
  - Capture buffer cleared; beat counter = 0.
- States: IDLE, STREAM, DONE.
- IDLE:
  - start=1 registers y_in into the buffer, sets beat=0, clears the running max (val 0, idx 0), and moves to STREAM.
  - out_valid rises in the next cycle, so first-beat latency is 1 cycle.
- STREAM:
  - out_data[i] = relu(buf[beat*LANES+i]): 0 if the MSB is set, else unchanged.
  - out_valid=1. out_data and out_last are stable while out_valid && !out_ready.
  - On accept (out_valid && out_ready):
    - Running max updates over the beat's LANES elements, lowest index first.
    - Update only on strictly greater, so ties keep the earliest index.
    - beat increments.
  - If the accepted beat is the last (beat == ROWS/LANES-1), go to DONE.
  - out_last = (beat == ROWS/LANES-1).
- DONE:
  - done=1 for exactly one cycle; out_valid=0.
  - argmax_idx/argmax_val registered with the final result, then go to IDLE.
  - argmax outputs hold until the next start is accepted.
- Arithmetic:
  - Comparison is unsigned on post-ReLU values (all non-negative).
  - No widening; an all-zero or all-negative vector gives idx 0, val 0.
- start while busy (STREAM/DONE) is ignored; the buffer is not overwritten.
- start in the same cycle as done is also ignored.
- Back-to-back runs: start accepted in the IDLE cycle right after DONE.
- Reset mid-stream aborts immediately; outputs take reset values and no done is issued.

Optional Feature:
- Macro: RELU_ARGMAX_ARGMAX_EN.
- Defined: argmax tracking as above.
- Undefined: no max comparator or registers; argmax_idx and argmax_val tied to 0.
- Streaming and done timing are identical in both builds.

Decomposition:
- Shared package `tinyml_pkg`:
  - state_t enum {IDLE, STREAM, DONE}.
  - Helper function relu(logic [DATA_WIDTH-1:0]).
  - Localparam BEATS = ROWS/LANES.
- One sub-module, `lane_max` (combinational): finds the maximum value and local index among LANES inputs, earliest index wins ties. Instantiated once; its result is compared against the running max in the parent.

Test Plan:
- ROWS=16, LANES=4; y_in[i]=i; start; out_ready=1:
  - out_valid at start+1 cycle.
  - 4 beats, beat0 = {0,1,2,3}, out_last on beat 3.
  - done at start+5; argmax_idx=15, argmax_val=15.
- y_in = all 0x80..0xFF (negative), with y_in[7]=0x9C:
  - Every out_data = 0.
  - argmax_idx=0, argmax_val=0.
- y_in[3]=0x50, y_in[9]=0x50, rest 0x10:
  - argmax_idx=3, argmax_val=0x50 (tie keeps the earliest index).
- Backpressure: out_ready low on cycles 2–4 and on every other cycle thereafter:
  - out_data/out_last stable while stalled.
  - Exactly 4 accepts; done only after the 4th accept.
- Second start mid-STREAM with different y_in:
  - Ignored; output matches the first vector.
  - A new start on the cycle after done is accepted and produces the new vector.
- Reset: rst=0 during beat 2:
  - All outputs 0 asynchronously, no done.
  - After release, a fresh run completes correctly.
  - With RELU_ARGMAX_ARGMAX_EN undefined, argmax outputs stay 0 throughout.
